fifo_rd_stream: RTL
===================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 Parameter WIDTH, default 8: data word width; SHALL equal the upstream async FIFO WIDTH.
REQ-002 Parameter CNT_W, default 16: width of the transfer counter.
REQ-003 rd_clk  in  1  single clock, the FIFO read-domain clock.
REQ-004 rd_rstn  in  1  asynchronous, active-low reset.
REQ-005 fifo_empty  in  1  FIFO empty_flag, registered in rd_clk domain.
REQ-006 fifo_rd_en  out  1  read request to the FIFO.
REQ-007 fifo_rd_data  in  WIDTH  FIFO read data, valid when fifo_rd_valid=1.
REQ-008 fifo_rd_valid  in  1  one-cycle pulse marking a returned FIFO word.
REQ-009 m_valid  out  1  output stream word valid.
REQ-010 m_ready  in  1  downstream accepts the word.
REQ-011 m_data  out  WIDTH  output stream data.
REQ-012 xfer_cnt  out  CNT_W  count of completed output transfers.
REQ-013 proto_err  out  1  sticky protocol-violation flag.

Function
REQ-014 The block SHALL hold a 3-entry in-order buffer with occupancy occ in 0..3.
REQ-015 The block SHALL track a 1-bit inflight register: set on each edge where fifo_rd_en=1 and fifo_empty=0; otherwise cleared.
REQ-016 fifo_rd_en SHALL be rd_rstn & ~fifo_empty & ((occ + inflight) < 3), from registers and fifo_empty only, with no path from m_ready.
REQ-017 A word with fifo_rd_valid=1 at edge N SHALL be written to the buffer tail at edge N.
REQ-018 m_valid SHALL equal (occ != 0), and m_data SHALL equal the buffer head, both driven from registers.
REQ-019 Latency: fifo_rd_en high in cycle 0 gives fifo_rd_valid in cycle 1 and m_valid in cycle 2 when the buffer is empty.
REQ-020 A pop SHALL occur on each edge where m_valid & m_ready; head advances and occ decrements.
REQ-021 Simultaneous push and pop SHALL leave occ unchanged and keep order.
REQ-022 Push into an empty buffer with m_ready=1 SHALL NOT bypass; the word is presented the following cycle.
REQ-023 While m_valid=1 and m_ready=0, m_data SHALL stay stable.
REQ-024 With fifo_empty=0 and m_ready=1 held, throughput SHALL be one word per cycle after the 2-cycle fill.
REQ-025 Buffer pointers SHALL wrap modulo 3 (2 -> 0).
REQ-026 xfer_cnt SHALL increment by 1 per pop, wrapping from 2^CNT_W-1 to 0.
REQ-027 proto_err SHALL set and stay set until reset on either violation:
- fifo_rd_valid=1 while inflight=0;
- fifo_rd_valid=1 while occ=3 with no pop.
REQ-028 On the second violation (overflow), the incoming word SHALL be dropped and buffer contents preserved.

Reset
REQ-029 Asserting rd_rstn low SHALL immediately clear occ, inflight, pointers, xfer_cnt and proto_err, and force m_valid=0 and fifo_rd_en=0.
REQ-030 m_data SHALL reset to 0; buffer storage need not reset.
REQ-031 Reset asserted mid-transfer SHALL discard buffered and in-flight words; a fifo_rd_valid arriving in the first cycle after deassertion SHALL set proto_err.

Structure
REQ-032 A shared package SHALL hold BUF_DEPTH=3, the default WIDTH=8 and CNT_W=16.
REQ-033 The 3-entry buffer SHALL be one sub-module, stream_buf3 (push, pop, occ, head data).
REQ-034 Counter, inflight tracking, request logic and error logic SHALL live in fifo_rd_stream.

Verification
REQ-035 Model FIFO holds 0x11,0x22,0x33; m_ready=1 -> m_data 0x11,0x22,0x33 on consecutive cycles, first m_valid 2 cycles after first fifo_rd_en, xfer_cnt=3.
REQ-036 FIFO supplies 10 words with m_ready=0 -> fifo_rd_en drops after 3 grants, occ=3, m_valid=1 with m_data=first word stable; release m_ready -> all 10 in order, xfer_cnt=10.
REQ-037 m_ready toggles 1010... over 20 words -> no loss or duplication, order kept, proto_err=0.
REQ-038 Inject fifo_rd_valid with no prior grant -> proto_err=1 next cycle, stays 1 until reset.
REQ-039 Preload xfer_cnt near wrap via 65536 transfers -> xfer_cnt reads 0 after transfer 65536.
REQ-040 Assert rd_rstn low with occ=2 -> m_valid=0, fifo_rd_en=0 and xfer_cnt=0 immediately, without a clock edge.

Source files
------------

// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants and pointer helper for the FIFO read-side streaming block.
package fifo_rd_stream_pkg;
  localparam int BUF_DEPTH = 3;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;

  typedef logic [1:0] ptr_t;

  // Pointers cycle 0 -> 1 -> 2 -> 0; a power-of-two wrap would skip an entry.
  function automatic ptr_t ptr_inc(ptr_t p);
    return (p == ptr_t'(BUF_DEPTH - 1)) ? ptr_t'(0) : p + ptr_t'(1);
  endfunction
endpackage

// File: rtl/fifo_rd_stream_buf3.sv
// Three-entry in-order buffer with a registered head word (no push-to-head bypass).
module stream_buf3
  import fifo_rd_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [1:0]       occ,
  output logic [WIDTH-1:0] head
);
  logic [WIDTH-1:0] mem [BUF_DEPTH];
  ptr_t rd_ptr, wr_ptr, rd_nxt;

  assign rd_nxt = ptr_inc(rd_ptr);

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;

  // head mirrors mem[rd_ptr] one edge early so the output is a flop, not a mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
      head   <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= rd_nxt;
      occ <= occ + 2'(push) - 2'(pop);
      if (pop && occ >= 2'd2)
        head <= mem[rd_nxt];
      else if (push && (occ == 2'd0 || (pop && occ == 2'd1)))
        head <= din;
    end
  end
endmodule

// File: rtl/fifo_rd_stream.sv
// Drains an async FIFO read port into a valid/ready stream with a 3-word skid buffer.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             rd_clk,
  input  logic             rd_rstn,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rd_data,
  input  logic             fifo_rd_valid,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic             proto_err
);
  logic [1:0] occ;
  logic       inflight, pop, push, overflow, orphan;

  // Credit check counts the outstanding read so a returning word always has room.
  assign fifo_rd_en = rd_rstn & ~fifo_empty & ((3'(occ) + 3'(inflight)) < 3'(BUF_DEPTH));
  assign m_valid    = (occ != 2'd0);
  assign pop        = m_valid & m_ready;
  assign orphan     = fifo_rd_valid & ~inflight;
  assign overflow   = fifo_rd_valid & (occ == 2'(BUF_DEPTH)) & ~pop;
  assign push       = fifo_rd_valid & ~overflow;

  stream_buf3 #(.WIDTH(WIDTH)) u_buf (
    .clk  (rd_clk),
    .rst_n(rd_rstn),
    .push (push),
    .pop  (pop),
    .din  (fifo_rd_data),
    .occ  (occ),
    .head (m_data)
  );

  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      inflight  <= 1'b0;
      xfer_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      inflight  <= fifo_rd_en;
      xfer_cnt  <= xfer_cnt + CNT_W'(pop);
      proto_err <= proto_err | orphan | overflow;
    end
  end
endmodule
